instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8; width of instruction address and PC.
REQ-002 Parameter DEPTH, default 2; prefetch FIFO entries, legal range 1-4.
REQ-003 The block SHALL have port clk_test, input, 1; clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1; synchronous, active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1; instruction memory read request.
REQ-006 The block SHALL have port imem_addr, output, ADDR_W; read address, valid while imem_req=1.
REQ-007 The block SHALL have port imem_ack, input, 1; memory accepted the request and imem_rdata is valid this cycle.
REQ-008 The block SHALL have port imem_rdata, input, 16; instruction word.
REQ-009 The block SHALL have port ir_load, input, 1; control unit requests the next instruction into IR.
REQ-010 The block SHALL have port pc_load, input, 1; control unit redirects fetch (jump/branch taken).
REQ-011 The block SHALL have port pc_target, input, ADDR_W; redirect address.
REQ-012 The block SHALL have port ir, output, 16; instruction register driven to the control unit IR input.
REQ-013 The block SHALL have port ir_valid, output, 1; ir holds a fetched, unflushed instruction.
REQ-014 The block SHALL have port pc, output, ADDR_W; address of the instruction held in ir.
REQ-015 The block SHALL have port stall, output, 1; combinational, ir_load=1 while FIFO empty and pc_load=0.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN; IDLE -> FETCH on the first cycle reset=1.
REQ-017 In FETCH, imem_req SHALL be 1 whenever FIFO count plus outstanding request is less than DEPTH; at most one request outstanding.
REQ-018 imem_req and imem_addr SHALL hold stable from assertion until the cycle imem_ack=1.
REQ-019 On imem_ack in FETCH, {imem_rdata, imem_addr} SHALL be pushed into the FIFO and fetch address SHALL increment by 1, wrapping 2^ADDR_W-1 -> 0.
REQ-020 On ir_load=1, pc_load=0 and FIFO non-empty, the FIFO head SHALL be loaded into ir/pc, ir_valid set to 1, and the entry popped at the next edge.
REQ-021 On ir_load=1 with FIFO empty, ir and pc SHALL hold, and ir_valid SHALL clear; stall=1 that cycle.
REQ-022 An instruction acked in cycle N SHALL be loadable into ir no earlier than the edge ending cycle N+1; no bypass from imem_rdata to ir.
REQ-023 Same-cycle push and pop SHALL be legal; count is unchanged.
REQ-024 On pc_load=1, the FIFO SHALL flush, ir_valid SHALL clear, fetch address SHALL load pc_target, and ir_load SHALL be ignored that cycle.
REQ-025 On pc_load with a request outstanding and no ack that cycle, the FSM SHALL go to DRAIN, hold the old request until ack, and discard the data; it SHALL then return to FETCH and request pc_target.
REQ-026 On pc_load with imem_ack in the same cycle, the acked data SHALL be discarded, and the FSM SHALL remain in FETCH.
REQ-027 On pc_load during DRAIN, pc_target SHALL overwrite the pending redirect address.

Reset
REQ-028 While reset=0 at a rising edge, the block SHALL set state IDLE, imem_req=0, imem_addr=0, fetch address 0, FIFO empty, ir=16'h0000, pc=0, ir_valid=0, and stall_count=0.
REQ-029 On reset mid-request, the request SHALL be abandoned, and ack/data arriving after reset SHALL be ignored until the block issues a new request.

Configuration
REQ-030 Macro IFU_STALL_COUNT_EN defined: the block SHALL add output stall_count[15:0], which increments each cycle stall=1 and saturates at 16'hFFFF.
REQ-031 Macro IFU_STALL_COUNT_EN undefined: the block SHALL have no stall_count port and no counter logic; all other behaviour is identical.

Verification
REQ-032 Release reset, memory acks every request on its first cycle, ir_load held high -> addresses 0,1,2... are requested back-to-back, ir_valid=1 from the third edge, and pc steps 0,1,2.
REQ-033 ir_load=0 with 1-cycle acks -> exactly DEPTH (2) requests issued, then imem_req=0 until an ir_load pops an entry.
REQ-034 Request for address 5 outstanding with ack delayed 3 cycles, pc_load=1 with pc_target=8'h40 -> addr 5 is held until ack, its data is never seen in ir, the next request is 8'h40, and ir_valid=0 until 8'h40 is loaded.
REQ-035 FIFO empty with ir_load=1 for 4 cycles -> stall=1 for 4 cycles, ir unchanged, and stall_count=4 with IFU_STALL_COUNT_EN defined.
REQ-036 Fetch address 8'hFF acked -> next request is 8'h00.
REQ-037 pc_load and ir_load high in the same cycle with FIFO non-empty -> FIFO flushed, ir unchanged, and ir_valid=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetch unit.
//
// Fetches 16-bit instruction words from instruction memory into a small
// prefetch FIFO. The FIFO feeds the instruction register (ir/pc) on request
// from the control unit. A redirect (pc_load) flushes the FIFO and restarts
// fetching at pc_target. A request that is still in flight when the redirect
// arrives is completed and its data discarded (DRAIN state).
//
// Optional feature: define IFU_STALL_COUNT_EN to add the stall_count output,
// a saturating count of stall cycles.
//
// Ports
//   clk_test     clock, rising edge
//   reset        synchronous, active-low reset
//   imem_req     instruction memory read request
//   imem_addr    read address, valid while imem_req=1
//   imem_ack     memory accepted the request; imem_rdata valid this cycle
//   imem_rdata   instruction word
//   ir_load      control unit requests the next instruction into ir
//   pc_load      control unit redirects fetch
//   pc_target    redirect address
//   ir           instruction register
//   ir_valid     ir holds a fetched, unflushed instruction
//   pc           address of the instruction held in ir
//   stall        ir_load requested while the FIFO is empty and no redirect
//   stall_count  saturating stall-cycle counter (IFU_STALL_COUNT_EN only)
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_test,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              ir_load,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [15:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              stall
`ifdef IFU_STALL_COUNT_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e r_state, w_state_next;

  logic [15:0]       r_fifo_data [DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [PtrW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]   r_count;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [ADDR_W-1:0] r_redir_addr;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ir_valid;

  logic w_empty, w_full, w_ack, w_push, w_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(DEPTH));

  always_ff @(posedge clk_test) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // The request level is derived from registered state only; the FIFO count
  // can only fall while a request waits, so the request stays asserted.
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    imem_addr    = r_fetch_addr;
    unique case (r_state)
      StIdle:  w_state_next = StFetch;
      StFetch: begin
        imem_req = !w_full;
        if (pc_load && !w_full && !imem_ack) w_state_next = StDrain;
      end
      StDrain: begin
        imem_req = 1'b1;
        if (imem_ack) w_state_next = StFetch;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_ack  = imem_req && imem_ack;
  assign w_push = (r_state == StFetch) && w_ack && !pc_load;
  assign w_pop  = ir_load && !pc_load && !w_empty;
  assign stall  = ir_load && w_empty && !pc_load;

  // FIFO storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk_test) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rdata;
      r_fifo_addr[r_wr_ptr] <= r_fetch_addr;
    end
  end

  always_ff @(posedge clk_test) begin
    if (!reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_fetch_addr <= '0;
      r_redir_addr <= '0;
      r_ir         <= 16'h0000;
      r_pc         <= '0;
      r_ir_valid   <= 1'b0;
    end else begin
      if (pc_load) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_ir_valid <= 1'b0;
      end else begin
        if (w_pop) begin
          r_ir       <= r_fifo_data[r_rd_ptr];
          r_pc       <= r_fifo_addr[r_rd_ptr];
          r_ir_valid <= 1'b1;
          r_rd_ptr   <= next_ptr(r_rd_ptr);
        end else if (ir_load) begin
          r_ir_valid <= 1'b0;
        end
        if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
        r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      end

      unique case (r_state)
        StIdle: begin
          if (pc_load) r_fetch_addr <= pc_target;
        end
        StFetch: begin
          // An unacked request must be held, so the target is parked.
          if (pc_load) begin
            if (imem_req && !imem_ack) r_redir_addr <= pc_target;
            else                       r_fetch_addr <= pc_target;
          end else if (w_push) begin
            r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
          end
        end
        StDrain: begin
          if (imem_ack)     r_fetch_addr <= pc_load ? pc_target : r_redir_addr;
          else if (pc_load) r_redir_addr <= pc_target;
        end
        default: ;
      endcase
    end
  end

  assign ir       = r_ir;
  assign pc       = r_pc;
  assign ir_valid = r_ir_valid;

`ifdef IFU_STALL_COUNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk_test) begin
    if (!reset)                                r_stall_count <= 16'h0000;
    else if (stall && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'h0001;
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit.
//
// A queue-based reference model of the fetch unit and a simple memory
// responder (configurable ack delay) run alongside the DUT. Directed
// scenarios are followed by a randomized run. Define IFU_STALL_COUNT_EN to
// also check stall_count.
module tb_instr_fetch_unit;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 2;

  localparam int MIdle  = 0;
  localparam int MFetch = 1;
  localparam int MDrain = 2;

  logic          clk_test   = 1'b0;
  logic          reset      = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack   = 1'b0;
  logic [15:0]   imem_rdata = 16'h0000;
  logic          ir_load    = 1'b0;
  logic          pc_load    = 1'b0;
  logic [AW-1:0] pc_target  = '0;
  logic [15:0]   ir;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic          stall;
`ifdef IFU_STALL_COUNT_EN
  logic [15:0]   stall_count;
`endif

  instr_fetch_unit #(
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk_test  (clk_test),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir_load   (ir_load),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .stall     (stall)
`ifdef IFU_STALL_COUNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk_test = ~clk_test;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            m_mode   = MIdle;
  logic [AW-1:0] m_fa     = '0;
  logic [AW-1:0] m_redir  = '0;
  logic [15:0]   m_qd[$];
  logic [AW-1:0] m_qa[$];
  logic [15:0]   m_ir     = 16'h0000;
  logic [AW-1:0] m_pc     = '0;
  logic          m_v      = 1'b0;
  int            m_stalls = 0;

  // Memory responder and monitors.
  bit            mem_busy  = 1'b0;
  int            mem_wait  = 0;
  int            dly_fixed = 0;
  int            n_acks    = 0;
  int            n_stall   = 0;
  logic [AW-1:0] ack_addrs[$];
  bit            seen5     = 1'b0;
  logic          obs_req;
  logic [AW-1:0] obs_addr;

  function automatic logic [15:0] mem_data(input logic [AW-1:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  function automatic logic m_req();
    return (m_mode == MFetch && m_qd.size() < int'(DEPTH)) || (m_mode == MDrain);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic step(input logic rst_n, input logic irl, input logic pcl, input logic [AW-1:0] tgt);
    logic          er, es, got;
    logic [AW-1:0] ea;
    @(negedge clk_test);
    reset     = rst_n;
    ir_load   = irl;
    pc_load   = pcl;
    pc_target = tgt;
    er        = m_req();
    ea        = m_fa;
    es        = irl && (m_qd.size() == 0) && !pcl;
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    if (!rst_n) begin
      mem_busy = 1'b0;
      imem_ack = ($urandom_range(0, 1) == 0);
    end else if (er) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 3));
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_data(ea);
        mem_busy   = 1'b0;
      end else begin
        mem_wait--;
      end
    end else begin
      // Stray acks while nothing is requested must be ignored.
      imem_ack = ($urandom_range(0, 3) == 0);
    end
    got = rst_n && er && imem_ack;
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    check("imem_req", 32'(imem_req), 32'(er));
    if (er) check("imem_addr", 32'(imem_addr), 32'(ea));
    check("stall", 32'(stall), 32'(es));
    if (stall) n_stall++;
    if (got) begin
      n_acks++;
      ack_addrs.push_back(ea);
    end

    @(posedge clk_test);
    if (!rst_n) begin
      m_mode = MIdle;
      m_fa = '0;
      m_redir = '0;
      m_qd.delete();
      m_qa.delete();
      m_ir = 16'h0000;
      m_pc = '0;
      m_v = 1'b0;
      m_stalls = 0;
    end else begin
      if (es && m_stalls < 65535) m_stalls++;
      if (pcl) begin
        m_qd.delete();
        m_qa.delete();
        m_v = 1'b0;
        if (m_mode == MIdle) begin
          m_fa = tgt;
          m_mode = MFetch;
        end else if (m_mode == MFetch) begin
          if (er && !got) begin
            m_redir = tgt;
            m_mode = MDrain;
          end else begin
            m_fa = tgt;
          end
        end else begin
          if (got) begin
            m_fa = tgt;
            m_mode = MFetch;
          end else begin
            m_redir = tgt;
          end
        end
      end else begin
        if (irl) begin
          if (m_qd.size() > 0) begin
            m_ir = m_qd.pop_front();
            m_pc = m_qa.pop_front();
            m_v = 1'b1;
          end else begin
            m_v = 1'b0;
          end
        end
        if (m_mode == MIdle) begin
          m_mode = MFetch;
        end else if (m_mode == MFetch) begin
          if (got) begin
            m_qd.push_back(mem_data(ea));
            m_qa.push_back(ea);
            m_fa = m_fa + 8'd1;
          end
        end else if (got) begin
          m_fa = m_redir;
          m_mode = MFetch;
        end
      end
    end
    #1;
    check("ir", 32'(ir), 32'(m_ir));
    check("pc", 32'(pc), 32'(m_pc));
    check("ir_valid", 32'(ir_valid), 32'(m_v));
`ifdef IFU_STALL_COUNT_EN
    check("stall_count", 32'(stall_count), 32'(m_stalls));
`endif
    if (ir_valid && pc == 8'h05 && ir == mem_data(8'h05)) seen5 = 1'b1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    n_acks = 0;
    n_stall = 0;
    ack_addrs.delete();
  endtask

  initial begin
    // Reset state.
    dly_fixed = 0;
    do_reset();
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);

    // Back-to-back fetch with immediate acks and ir_load held high.
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    check("b2b_valid3", 32'(ir_valid), 32'h1);
    check("b2b_pc0", 32'(pc), 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("b2b_pc1", 32'(pc), 32'h1);
    step(1'b1, 1'b1, 1'b0, '0);
    check("b2b_pc2", 32'(pc), 32'h2);
    check("b2b_nacks", 32'(ack_addrs.size()), 32'd4);
    for (int i = 0; i < ack_addrs.size(); i++) check("b2b_addr", 32'(ack_addrs[i]), 32'(i));

    // No ir_load: exactly DEPTH requests, then idle until a pop.
    do_reset();
    repeat (8) step(1'b1, 1'b0, 1'b0, '0);
    check("fill_acks", 32'(n_acks), 32'(DEPTH));
    check("fill_req_low", 32'(obs_req), 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("refill_req", 32'(obs_req), 32'h1);

    // Redirect while a delayed request to address 5 is outstanding.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 8'h05);
    dly_fixed = 3;
    seen5 = 1'b0;
    step(1'b1, 1'b1, 1'b0, '0);
    check("drain_addr_a", 32'(obs_addr), 32'h05);
    step(1'b1, 1'b1, 1'b1, 8'h40);
    check("drain_addr_b", 32'(obs_addr), 32'h05);
    step(1'b1, 1'b1, 1'b0, '0);
    check("drain_addr_c", 32'(obs_addr), 32'h05);
    step(1'b1, 1'b1, 1'b0, '0);
    check("drain_addr_d", 32'(obs_addr), 32'h05);
    dly_fixed = 0;
    step(1'b1, 1'b1, 1'b0, '0);
    check("redir_req", 32'(obs_req), 32'h1);
    check("redir_addr", 32'(obs_addr), 32'h40);
    check("redir_valid0", 32'(ir_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("redir_valid1", 32'(ir_valid), 32'h1);
    check("redir_pc", 32'(pc), 32'h40);
    check("drain_discard", 32'(seen5), 32'h0);

    // Stall on an empty FIFO for four cycles.
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    dly_fixed = 7;
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    check("stall_cycles", 32'(n_stall), 32'd4);
    check("stall_ir", 32'(ir), 32'h0);
    check("stall_valid", 32'(ir_valid), 32'h0);
`ifdef IFU_STALL_COUNT_EN
    check("stall_count4", 32'(stall_count), 32'd4);
`endif

    // Fetch address wrap from 8'hFF to 8'h00.
    do_reset();
    dly_fixed = 0;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 8'hFF);
    ack_addrs.delete();
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    check("wrap_n", 32'(ack_addrs.size()), 32'd3);
    check("wrap_ff", 32'(ack_addrs[0]), 32'hFF);
    check("wrap_00", 32'(ack_addrs[1]), 32'h00);

    // pc_load and ir_load together with a non-empty FIFO.
    do_reset();
    repeat (5) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("flush_pre_ir", 32'(ir), 32'(mem_data(8'h00)));
    step(1'b1, 1'b1, 1'b1, 8'h80);
    check("flush_ir", 32'(ir), 32'(mem_data(8'h00)));
    check("flush_valid", 32'(ir_valid), 32'h0);
    check("flush_pc", 32'(pc), 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("flush_stall", 32'(n_stall), 32'd1);

    // Randomized run against the model.
    do_reset();
    dly_fixed = -1;
    for (int i = 0; i < 3000; i++) begin
      logic          r_rst, r_irl, r_pcl;
      logic [AW-1:0] r_tgt;
      r_rst = ($urandom_range(0, 299) != 0);
      r_irl = ($urandom_range(0, 2) != 0);
      r_pcl = ($urandom_range(0, 15) == 0);
      r_tgt = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      step(r_rst, r_irl, r_pcl, r_tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
